// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative 32-bit multiply/divide unit with HI/LO registers and fixed 33-cycle latency.
// Build macro MDU_DIV_EN enables DIV/DIVU; without it those opcodes are no-ops and no divider exists.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO write hi/lo directly
// S_CALC | one radix-2 step per cycle on operand magnitudes, ITER cycles
// S_FIX  | sign correction, hi/lo written at the closing edge, done follows

module mdu_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int ITER = 32;
   localparam logic [4:0] LAST = 5'(ITER - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
   state_t state, state_nx;

   logic [4:0]  cnt;
   logic [31:0] opb;
   logic [31:0] acc_hi, acc_lo;
   logic        neg_q;
   logic        is_mul, is_div, accept, sgn;
   logic [31:0] mag_a, mag_b;
   logic [32:0] sum;
   logic [31:0] step_hi, step_lo;
   logic [63:0] prod, prod_fix;
   logic [31:0] fix_hi, fix_lo;
`ifdef MDU_DIV_EN
   logic        op_div, neg_r, dz;
   logic [32:0] shl, diff;
`endif

   always_comb begin
      is_mul = start && (op[2:1] == 2'b00);
`ifdef MDU_DIV_EN
      is_div = start && (op[2:1] == 2'b01);
`else
      is_div = 1'b0;
`endif
      accept = (state == S_IDLE) && (is_mul || is_div);
      sgn    = ~op[0];
      mag_a  = (sgn && A[31]) ? -A : A;
      mag_b  = (sgn && B[31]) ? -B : B;
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_CALC;
         S_CALC:  if (cnt == LAST) state_nx = S_FIX;
         S_FIX:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // outputs
   always_comb busy = (state != S_IDLE);

   // One iteration: multiply shifts the product right through acc_lo,
   // divide shifts the dividend left out of acc_lo into the remainder.
   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
      step_hi = sum[32:1];
      step_lo = {sum[0], acc_lo[31:1]};
`ifdef MDU_DIV_EN
      shl  = {acc_hi, acc_lo[31]};
      diff = shl - {1'b0, opb};
      if (op_div) begin
         if (shl >= {1'b0, opb}) begin
            step_hi = diff[31:0];
            step_lo = {acc_lo[30:0], 1'b1};
         end else begin
            step_hi = shl[31:0];
            step_lo = {acc_lo[30:0], 1'b0};
         end
      end
`endif
   end

   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_fix = neg_q ? -prod : prod;
      fix_hi   = prod_fix[63:32];
      fix_lo   = prod_fix[31:0];
`ifdef MDU_DIV_EN
      // divide by zero leaves |A| as remainder, so only the quotient needs overriding
      if (op_div) begin
         fix_hi = neg_r ? -acc_hi : acc_hi;
         fix_lo = dz ? 32'hFFFF_FFFF : (neg_q ? -acc_lo : acc_lo);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         opb    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         neg_q  <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
`ifdef MDU_DIV_EN
         op_div <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
`endif
      end else begin
         done <= (state == S_FIX);
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cnt    <= '0;
                  acc_hi <= '0;
                  neg_q  <= sgn && (A[31] ^ B[31]);
                  opb    <= is_div ? mag_b : mag_a;
                  acc_lo <= is_div ? mag_a : mag_b;
`ifdef MDU_DIV_EN
                  op_div <= is_div;
                  neg_r  <= sgn && A[31];
                  dz     <= (B == 32'd0);
`endif
               end else if (start && op == 3'b100) begin
                  hi <= A;
               end else if (start && op == 3'b101) begin
                  lo <= A;
               end
            end
            S_CALC: begin
               cnt    <= cnt + 5'd1;
               acc_hi <= step_hi;
               acc_lo <= step_lo;
            end
            S_FIX: begin
               hi <= fix_hi;
               lo <= fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized and directed checks of mdu_ctrl against an arithmetic reference model.
// Honours MDU_DIV_EN the same way as the design (divides become no-ops when undefined).

module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  op;
   logic [31:0] A, B;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_tot = 0;
   int n_bad = 0;
   logic [31:0] m_hi, m_lo;

   mdu_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: returns 1 when the op is an accepted MULT/DIV, with the resulting hi/lo.
   function automatic bit model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
      longint      sp, sa, sb, q, r;
      logic [63:0] up;
      eh = 32'd0;
      el = 32'd0;
      case (o)
         3'd0: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            eh = sp[63:32];
            el = sp[31:0];
            return 1'b1;
         end
         3'd1: begin
            up = {32'd0, a} * {32'd0, b};
            eh = up[63:32];
            el = up[31:0];
            return 1'b1;
         end
`ifdef MDU_DIV_EN
         3'd2, 3'd3: begin
            if (b == 32'd0) begin
               eh = a;
               el = 32'hFFFF_FFFF;
            end else if (o == 3'd2) begin
               sa = longint'($signed(a));
               sb = longint'($signed(b));
               q  = sa / sb;
               r  = sa % sb;
               eh = r[31:0];
               el = q[31:0];
            end else begin
               eh = a % b;
               el = a / b;
            end
            return 1'b1;
         end
`endif
         default: return 1'b0;
      endcase
   endfunction

   // Issues a MULT/DIV; optionally injects a start with inj_op during busy cycle inj_cyc.
   // Returns in the done cycle so a caller can start back-to-back.
   task automatic do_muldiv(input string tag, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input int inj_cyc, input logic [2:0] inj_op);
      logic [31:0] eh, el;
      int  cyc;
      bit  hold_ok, done_ok;
      bit  acc;
      acc = model(o, a, b, eh, el);
      start = 1'b1; op = o; A = a; B = b;
      tick;
      start = 1'b0;
      check({tag, " done_low_e0"}, done, 0);
      if (!acc) begin
         check({tag, " noop_busy"}, busy, 0);
         check({tag, " noop_hi"}, hi, m_hi);
         check({tag, " noop_lo"}, lo, m_lo);
         return;
      end
      cyc = 0; hold_ok = 1'b1; done_ok = 1'b1;
      while (busy === 1'b1 && cyc < 40) begin
         if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
         if (done !== 1'b0) done_ok = 1'b0;
         if (cyc == inj_cyc) begin
            start = 1'b1; op = inj_op; A = $urandom; B = $urandom;
         end else begin
            start = 1'b0;
         end
         cyc++;
         tick;
      end
      start = 1'b0;
      check({tag, " latency"}, cyc, 33);
      check({tag, " hold"}, hold_ok, 1);
      check({tag, " no_early_done"}, done_ok, 1);
      check({tag, " done"}, done, 1);
      check({tag, " hi"}, hi, eh);
      check({tag, " lo"}, lo, el);
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic do_mt(input string tag, input logic [2:0] o, input logic [31:0] a);
      start = 1'b1; op = o; A = a; B = $urandom;
      tick;
      start = 1'b0;
      if (o == 3'd4) m_hi = a;
      if (o == 3'd5) m_lo = a;
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " hi"}, hi, m_hi);
      check({tag, " lo"}, lo, m_lo);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         4: return 32'($urandom_range(0, 50));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bit done_seen;
      logic [2:0] ro;
      reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
      m_hi = 32'd0; m_lo = 32'd0;
      tick; tick;
      reset = 1'b0;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst hi", hi, 0);
      check("rst lo", lo, 0);

      do_muldiv("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, -1, 3'd0);
      tick;
      check("mult_neg done_once", done, 0);
      do_muldiv("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 3'd0);
      do_muldiv("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, -1, 3'd0);
      do_muldiv("divu_100_7", 3'd3, 32'd100, 32'd7, -1, 3'd0);
      do_muldiv("divu_by0", 3'd3, 32'd9, 32'd0, -1, 3'd0);
      do_muldiv("div_by0_neg", 3'd2, 32'hFFFF_FFF0, 32'd0, -1, 3'd0);
      do_muldiv("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 3'd0);
      tick;
      do_mt("mthi", 3'd4, 32'h1234_5678);
      do_mt("mtlo", 3'd5, 32'h9ABC_DEF0);
      do_mt("nop6", 3'd6, 32'h5555_5555);
      do_mt("nop7", 3'd7, 32'hAAAA_AAAA);
      do_muldiv("mtlo_busy", 3'd1, 32'd3, 32'd4, 3, 3'd5);
      tick;
      do_muldiv("mult_restart", 3'd0, 32'hFFFF_FF00, 32'd77, 5, 3'd0);
      do_muldiv("b2b", 3'd1, 32'h0001_0000, 32'h0001_0000, -1, 3'd0);

      // reset in the middle of a multiply
      start = 1'b1; op = 3'd0; A = 32'h0000_1234; B = 32'h0000_5678;
      tick;
      start = 1'b0;
      repeat (9) tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      check("midrst busy", busy, 0);
      check("midrst hi", hi, 0);
      check("midrst lo", lo, 0);
      done_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
         tick;
      end
      check("midrst quiet", done_seen, 0);

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         if (ro >= 3'd4) do_mt("rnd_mt", ro, $urandom);
         else do_muldiv("rnd", ro, rnd_operand(), rnd_operand(),
                        int'($urandom_range(0, 50)), 3'($urandom_range(0, 7)));
         repeat ($urandom_range(0, 2)) tick;
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
